alu_rsv_station: RTL and testbench

- Reservation station directly upstream of the ALU functional unit in the Tomasulo-style core.
- Buffers issued ALU ops and captures operands from the CDB until both are ready.
- Dispatches one op at a time over the FU's EN/finish protocol, then holds the tagged result for the CDB arbiter.

---
 rtl/alu_rsv_station.sv | 204 ++++++++++++++++++++
 tb/tb_alu_rsv_station.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rsv_station.sv
// Reservation station in front of the ALU: buffers issued ops, snoops the CDB for operands,
// dispatches one op at a time and holds the result for the CDB arbiter.
// Optional occupancy counter output `occ` is enabled by defining ALU_RSV_STATION_OCC_EN.
module alu_rsv_station #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       issue_ctrl,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic [31:0]      issue_vj,
    input  logic [TAG_W-1:0] issue_qk,
    input  logic [31:0]      issue_vk,
    input  logic [TAG_W-1:0] issue_dest,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             fu_en,
    output logic [3:0]       fu_ctrl,
    output logic [31:0]      fu_a,
    output logic [31:0]      fu_b,
    input  logic             fu_finish,
    input  logic [31:0]      fu_res,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_data
`ifdef ALU_RSV_STATION_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e state_q, state_d;

    logic [DEPTH-1:0] valid_q;
    logic [3:0]       ctrl_q [DEPTH];
    logic [TAG_W-1:0] qj_q   [DEPTH];
    logic [31:0]      vj_q   [DEPTH];
    logic [TAG_W-1:0] qk_q   [DEPTH];
    logic [31:0]      vk_q   [DEPTH];
    logic [TAG_W-1:0] dest_q [DEPTH];

    logic [TAG_W-1:0] exec_tag_q;
    logic             wb_valid_q;
    logic [TAG_W-1:0] wb_tag_q;
    logic [31:0]      wb_data_q;

    logic            free_found, rdy_found;
    logic [IdxW-1:0] free_idx, rdy_idx;
    logic            issue_fire, dispatch, cdb_hit;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
            if (valid_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0)) begin
                rdy_found = 1'b1;
                rdy_idx   = IdxW'(i);
            end
        end
    end

    assign issue_ready = free_found;
    assign issue_fire  = issue_valid && free_found;
    assign cdb_hit     = cdb_valid && (cdb_tag != '0);
    assign dispatch    = (state_q == StIdle) && rdy_found && !wb_valid_q;

    always_comb begin
        fu_en   = 1'b0;
        fu_ctrl = '0;
        fu_a    = '0;
        fu_b    = '0;
        if (dispatch) begin
            fu_en   = 1'b1;
            fu_ctrl = ctrl_q[rdy_idx];
            fu_a    = vj_q[rdy_idx];
            fu_b    = vk_q[rdy_idx];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (dispatch)  state_d = StExec;
            StExec:  if (fu_finish) state_d = StWb;
            StWb:    if (wb_ready)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue only targets a free entry and dispatch only a valid one, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_fire && (free_idx == IdxW'(i))) begin
                    valid_q[i] <= 1'b1;
                end else if (dispatch && (rdy_idx == IdxW'(i))) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Payload needs no reset: it is only observed while the matching valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_fire && (free_idx == IdxW'(i))) begin
                ctrl_q[i] <= issue_ctrl;
                dest_q[i] <= issue_dest;
                if (cdb_hit && (issue_qj == cdb_tag)) begin
                    qj_q[i] <= '0;
                    vj_q[i] <= cdb_data;
                end else begin
                    qj_q[i] <= issue_qj;
                    vj_q[i] <= issue_vj;
                end
                if (cdb_hit && (issue_qk == cdb_tag)) begin
                    qk_q[i] <= '0;
                    vk_q[i] <= cdb_data;
                end else begin
                    qk_q[i] <= issue_qk;
                    vk_q[i] <= issue_vk;
                end
            end else if (valid_q[i] && cdb_hit) begin
                if (qj_q[i] == cdb_tag) begin
                    qj_q[i] <= '0;
                    vj_q[i] <= cdb_data;
                end
                if (qk_q[i] == cdb_tag) begin
                    qk_q[i] <= '0;
                    vk_q[i] <= cdb_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_tag_q <= '0;
            wb_valid_q <= 1'b0;
            wb_tag_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            if (dispatch) begin
                exec_tag_q <= dest_q[rdy_idx];
            end
            if ((state_q == StExec) && fu_finish) begin
                wb_valid_q <= 1'b1;
                wb_tag_q   <= exec_tag_q;
                wb_data_q  <= fu_res;
            end else if ((state_q == StWb) && wb_ready) begin
                wb_valid_q <= 1'b0;
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_tag   = wb_tag_q;
    assign wb_data  = wb_data_q;

`ifdef ALU_RSV_STATION_OCC_EN
    localparam int unsigned OccW = $clog2(DEPTH + 1);

    logic [OccW-1:0] occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (issue_fire && !dispatch) begin
            occ_q <= occ_q + OccW'(1);
        end else if (!issue_fire && dispatch) begin
            occ_q <= occ_q - OccW'(1);
        end
    end

    assign occ = occ_q;
`endif

endmodule

// File: tb/tb_alu_rsv_station.sv
// Directed bench for alu_rsv_station: hand-computed vectors checked with immediate assertions.
module tb_alu_rsv_station;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_ready;
    logic [3:0]  issue_ctrl;
    logic [2:0]  issue_qj, issue_qk, issue_dest;
    logic [31:0] issue_vj, issue_vk;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        fu_en;
    logic [3:0]  fu_ctrl;
    logic [31:0] fu_a, fu_b;
    logic        fu_finish;
    logic [31:0] fu_res;
    logic        wb_valid, wb_ready;
    logic [2:0]  wb_tag;
    logic [31:0] wb_data;
`ifdef ALU_RSV_STATION_OCC_EN
    logic [2:0]  occ;
`endif

    int vectors = 0;
    int miscompares = 0;

    alu_rsv_station #(.DEPTH(4), .TAG_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_ctrl(issue_ctrl),
        .issue_qj(issue_qj), .issue_vj(issue_vj), .issue_qk(issue_qk), .issue_vk(issue_vk),
        .issue_dest(issue_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fu_en(fu_en), .fu_ctrl(fu_ctrl), .fu_a(fu_a), .fu_b(fu_b),
        .fu_finish(fu_finish), .fu_res(fu_res),
`ifdef ALU_RSV_STATION_OCC_EN
        .occ(occ),
`endif
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] ctrl, input logic [2:0] qj, input logic [31:0] vj,
                         input logic [2:0] qk, input logic [31:0] vk, input logic [2:0] dest);
        issue_valid = 1'b1;
        issue_ctrl  = ctrl;
        issue_qj    = qj;
        issue_vj    = vj;
        issue_qk    = qk;
        issue_vk    = vk;
        issue_dest  = dest;
    endtask

    initial begin
        rst_n = 1'b0;
        issue_valid = 1'b0; issue_ctrl = '0; issue_qj = '0; issue_vj = '0;
        issue_qk = '0; issue_vk = '0; issue_dest = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        fu_finish = 1'b0; fu_res = '0; wb_ready = 1'b1;

        // Reset state
        #12;
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_tag", 32'(wb_tag), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_fu_en", 32'(fu_en), 32'd0);
`ifdef ALU_RSV_STATION_OCC_EN
        check("rst_occ", 32'(occ), 32'd0);
`endif
        rst_n = 1'b1;
        step();

        // ADD with both operands present
        issue(4'b0001, 3'd0, 32'd5, 3'd0, 32'd7, 3'd3);
        step();
        issue_valid = 1'b0;
        check("add_fu_en", 32'(fu_en), 32'd1);
        check("add_fu_a", fu_a, 32'd5);
        check("add_fu_b", fu_b, 32'd7);
        check("add_fu_ctrl", 32'(fu_ctrl), 32'd1);
        step();
        check("add_exec_fu_en", 32'(fu_en), 32'd0);
        check("add_exec_wb_valid", 32'(wb_valid), 32'd0);
        fu_finish = 1'b1; fu_res = 32'd12;
        step();
        fu_finish = 1'b0;
        check("add_wb_valid", 32'(wb_valid), 32'd1);
        check("add_wb_tag", 32'(wb_tag), 32'd3);
        check("add_wb_data", wb_data, 32'd12);
        step();
        check("add_wb_done", 32'(wb_valid), 32'd0);

        // SUB waiting on tag 2, broadcast three cycles later
        issue(4'b0010, 3'd2, 32'd0, 3'd0, 32'd1, 3'd4);
        step();
        issue_valid = 1'b0;
        check("sub_wait0_fu_en", 32'(fu_en), 32'd0);
        step();
        check("sub_wait1_fu_en", 32'(fu_en), 32'd0);
        step();
        check("sub_wait2_fu_en", 32'(fu_en), 32'd0);
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'd10;
        #1;
        check("sub_bcast_fu_en", 32'(fu_en), 32'd0);
        step();
        cdb_valid = 1'b0;
        check("sub_fu_en", 32'(fu_en), 32'd1);
        check("sub_fu_a", fu_a, 32'd10);
        check("sub_fu_b", fu_b, 32'd1);
        check("sub_fu_ctrl", 32'(fu_ctrl), 32'd2);
        step();
        fu_finish = 1'b1; fu_res = 32'd9;
        step();
        fu_finish = 1'b0;
        check("sub_wb_tag", 32'(wb_tag), 32'd4);
        check("sub_wb_data", wb_data, 32'd9);
        step();

        // Same-cycle CDB bypass on issue
        issue(4'b0001, 3'd4, 32'd0, 3'd0, 32'd3, 3'd6);
        cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 32'h20;
        step();
        issue_valid = 1'b0; cdb_valid = 1'b0;
        check("byp_fu_en", 32'(fu_en), 32'd1);
        check("byp_fu_a", fu_a, 32'h20);
        check("byp_fu_b", fu_b, 32'd3);
        step();
        fu_finish = 1'b1; fu_res = 32'h23;
        step();
        fu_finish = 1'b0;
        check("byp_wb_tag", 32'(wb_tag), 32'd6);
        check("byp_wb_data", wb_data, 32'h23);
        step();

        // Fill all entries waiting on tag 5, then a fifth request that must be ignored
        for (int i = 0; i < 4; i++) begin
            issue(4'b0001, 3'd5, 32'd0, 3'd0, 32'(100 + i), 3'(i + 1));
            step();
        end
        check("full_issue_ready", 32'(issue_ready), 32'd0);
`ifdef ALU_RSV_STATION_OCC_EN
        check("full_occ", 32'(occ), 32'd4);
`endif
        issue(4'b0001, 3'd0, 32'd1, 3'd0, 32'd1, 3'd7);
        step();
        issue_valid = 1'b0;
        check("full_ignored_ready", 32'(issue_ready), 32'd0);
        check("full_no_fu_en", 32'(fu_en), 32'd0);
`ifdef ALU_RSV_STATION_OCC_EN
        check("full_ignored_occ", 32'(occ), 32'd4);
`endif
        cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 32'd50;
        step();
        cdb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("order_fu_en", 32'(fu_en), 32'd1);
            check("order_fu_a", fu_a, 32'd50);
            check("order_fu_b", fu_b, 32'(100 + i));
            step();
            fu_finish = 1'b1; fu_res = 32'(i * 2);
            step();
            fu_finish = 1'b0;
            check("order_wb_tag", 32'(wb_tag), 32'(i + 1));
            check("order_wb_data", wb_data, 32'(i * 2));
            step();
        end
        check("drained_fu_en", 32'(fu_en), 32'd0);
        check("drained_issue_ready", 32'(issue_ready), 32'd1);

        // Writeback back-pressure with a ready op pending
        wb_ready = 1'b0;
        issue(4'b0001, 3'd0, 32'd1, 3'd0, 32'd2, 3'd1);
        step();
        check("bp_a_fu_en", 32'(fu_en), 32'd1);
        issue(4'b0001, 3'd0, 32'd3, 3'd0, 32'd4, 3'd2);
        step();
        issue_valid = 1'b0;
        fu_finish = 1'b1; fu_res = 32'd3;
        step();
        fu_finish = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_wb_valid", 32'(wb_valid), 32'd1);
            check("bp_wb_tag", 32'(wb_tag), 32'd1);
            check("bp_wb_data", wb_data, 32'd3);
            check("bp_no_fu_en", 32'(fu_en), 32'd0);
            step();
        end
        wb_ready = 1'b1;
        #1;
        check("bp_accept_fu_en", 32'(fu_en), 32'd0);
        step();
        check("bp_after_wb_valid", 32'(wb_valid), 32'd0);
        check("bp_next_fu_en", 32'(fu_en), 32'd1);
        check("bp_next_fu_a", fu_a, 32'd3);
        check("bp_next_fu_b", fu_b, 32'd4);
        step();
        fu_finish = 1'b1; fu_res = 32'd7;
        step();
        fu_finish = 1'b0;
        check("bp_b_wb_tag", 32'(wb_tag), 32'd2);
        check("bp_b_wb_data", wb_data, 32'd7);
        step();

        // Asynchronous reset while EXEC with the station full
        issue(4'b0001, 3'd0, 32'd8, 3'd0, 32'd9, 3'd5);
        step();
        check("rx_fu_en", 32'(fu_en), 32'd1);
        for (int i = 0; i < 4; i++) begin
            issue(4'b0001, 3'd6, 32'd0, 3'd0, 32'd1, 3'(i + 1));
            step();
        end
        issue_valid = 1'b0;
        check("rx_full_ready", 32'(issue_ready), 32'd0);
        check("rx_exec_fu_en", 32'(fu_en), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rx_wb_valid", 32'(wb_valid), 32'd0);
        check("rx_issue_ready", 32'(issue_ready), 32'd1);
        check("rx_fu_en_low", 32'(fu_en), 32'd0);
`ifdef ALU_RSV_STATION_OCC_EN
        check("rx_occ", 32'(occ), 32'd0);
`endif
        #2;
        rst_n = 1'b1;
        fu_finish = 1'b1; fu_res = 32'd99;
        step();
        fu_finish = 1'b0;
        check("rx_finish_ignored", 32'(wb_valid), 32'd0);
        step();
        check("rx_no_wb", 32'(wb_valid), 32'd0);
        cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 32'd1;
        step();
        cdb_valid = 1'b0;
        check("rx_entries_cleared", 32'(fu_en), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
